// File: rtl/getir_birimi_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface getir_birimi_if;
  logic        bellek_istek_gecerli;
  logic        bellek_istek_hazir;
  logic [31:0] bellek_istek_adres;
  logic        bellek_yanit_gecerli;
  logic [31:0] bellek_yanit_buyruk;

  modport master (
    output bellek_istek_gecerli,
    output bellek_istek_adres,
    input  bellek_istek_hazir,
    input  bellek_yanit_gecerli,
    input  bellek_yanit_buyruk
  );

  modport slave (
    input  bellek_istek_gecerli,
    input  bellek_istek_adres,
    output bellek_istek_hazir,
    output bellek_yanit_gecerli,
    output bellek_yanit_buyruk
  );
endinterface

// File: rtl/getir_birimi.sv
// Fetch stage: generates fetch addresses, tracks outstanding memory requests,
// filters responses by expected address and buffers them for the predictor
// and decode. Predictor and execute redirects steer the next fetch address.
module getir_birimi #(
  parameter logic [31:0] BASLANGIC_PS    = 32'h0000_0000,
  parameter int unsigned ISTEK_MAX       = 2,
  parameter int unsigned TAMPON_DERINLIK = 2
) (
  input  logic           clk,
  input  logic           rst,
  getir_birimi_if.master bellek,
  input  logic           ongoru_dallan,
  input  logic [31:0]    ongoru_dallan_ps,
  input  logic           duzelt_gecerli,
  input  logic [31:0]    duzelt_ps,
  input  logic           coz_hazir,
  output logic [31:0]    getir_ps,
  output logic [31:0]    getir_buyruk,
  output logic           getir_gecerli
);

  localparam int unsigned IW = (ISTEK_MAX > 1) ? $clog2(ISTEK_MAX) : 1;
  localparam int unsigned TW = (TAMPON_DERINLIK > 1) ? $clog2(TAMPON_DERINLIK) : 1;
  localparam int unsigned BW = $clog2(ISTEK_MAX + 1);
  localparam int unsigned DW = $clog2(TAMPON_DERINLIK + 1);
  localparam logic [IW-1:0] I_SON = IW'(ISTEK_MAX - 1);
  localparam logic [TW-1:0] T_SON = TW'(TAMPON_DERINLIK - 1);

  // Fetch address state.
  logic [31:0]   istek_ps;
  logic [31:0]   beklenen_ps;

  // Outstanding request addresses; occupancy equals bekleyen.
  logic [31:0]   adres_mem [ISTEK_MAX];
  logic [IW-1:0] adres_bas;
  logic [IW-1:0] adres_son;
  logic [BW-1:0] bekleyen;

  // Output instruction buffer.
  logic [31:0]   cikis_ps_mem     [TAMPON_DERINLIK];
  logic [31:0]   cikis_buyruk_mem [TAMPON_DERINLIK];
  logic [TW-1:0] cikis_bas;
  logic [TW-1:0] cikis_son;
  logic [DW-1:0] doluluk;

  // Per-cycle decisions.
  logic          istek_izin;
  logic          istek_ver;
  logic          yanit_al;
  logic [31:0]   yanit_adres;
  logic          yanit_eslesti;
  logic          tuket;
  logic [31:0]   ongoru_hedef;
  logic [31:0]   duzelt_hedef;
  logic          ongoru_yonlendir;
  logic          cikis_it;

  function automatic logic [IW-1:0] adres_sonraki(input logic [IW-1:0] p);
    return (p == I_SON) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [TW-1:0] cikis_sonraki(input logic [TW-1:0] p);
    return (p == T_SON) ? '0 : p + 1'b1;
  endfunction

  // A request is only offered when every outstanding response is guaranteed
  // a buffer slot, so the buffer can never overflow on an accepted response.
  always_comb begin
    istek_izin = (32'(bekleyen) < ISTEK_MAX)
              && ((32'(bekleyen) + 32'(doluluk)) < TAMPON_DERINLIK)
              && !duzelt_gecerli;
    bellek.bellek_istek_gecerli = !rst && istek_izin;
    bellek.bellek_istek_adres   = istek_ps;
    istek_ver = bellek.bellek_istek_gecerli && bellek.bellek_istek_hazir;

    // Responses with nothing outstanding are stale and ignored.
    yanit_al      = bellek.bellek_yanit_gecerli && (bekleyen != '0);
    yanit_adres   = adres_mem[adres_bas];
    yanit_eslesti = yanit_al && (yanit_adres == beklenen_ps);

    getir_gecerli = (doluluk != '0);
    getir_ps      = getir_gecerli ? cikis_ps_mem[cikis_bas]     : 32'h0;
    getir_buyruk  = getir_gecerli ? cikis_buyruk_mem[cikis_bas] : 32'h0;
    tuket         = getir_gecerli && coz_hazir;

    ongoru_hedef = {ongoru_dallan_ps[31:2], 2'b00};
    duzelt_hedef = {duzelt_ps[31:2], 2'b00};

    // A taken prediction to the fall-through address changes nothing.
    ongoru_yonlendir = tuket && ongoru_dallan && (ongoru_hedef != (getir_ps + 32'd4));

    // Any redirect discards the response arriving in the same cycle; the
    // response still retires its outstanding slot.
    cikis_it = yanit_eslesti && !duzelt_gecerli && !ongoru_yonlendir;
  end

  // Control state: fetch pointers, outstanding count and buffer pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      istek_ps    <= BASLANGIC_PS;
      beklenen_ps <= BASLANGIC_PS;
      adres_bas   <= '0;
      adres_son   <= '0;
      bekleyen    <= '0;
      cikis_bas   <= '0;
      cikis_son   <= '0;
      doluluk     <= '0;
    end else begin
      if (istek_ver) begin
        adres_son <= adres_sonraki(adres_son);
      end
      if (yanit_al) begin
        adres_bas <= adres_sonraki(adres_bas);
      end
      if (istek_ver && !yanit_al) begin
        bekleyen <= bekleyen + 1'b1;
      end else if (!istek_ver && yanit_al) begin
        bekleyen <= bekleyen - 1'b1;
      end

      if (duzelt_gecerli) begin
        istek_ps    <= duzelt_hedef;
        beklenen_ps <= duzelt_hedef;
      end else if (ongoru_yonlendir) begin
        istek_ps    <= ongoru_hedef;
        beklenen_ps <= ongoru_hedef;
      end else begin
        if (istek_ver) begin
          istek_ps <= istek_ps + 32'd4;
        end
        if (cikis_it) begin
          beklenen_ps <= beklenen_ps + 32'd4;
        end
      end

      if (duzelt_gecerli || ongoru_yonlendir) begin
        cikis_bas <= '0;
        cikis_son <= '0;
        doluluk   <= '0;
      end else begin
        if (cikis_it) begin
          cikis_son <= cikis_sonraki(cikis_son);
        end
        if (tuket) begin
          cikis_bas <= cikis_sonraki(cikis_bas);
        end
        if (cikis_it && !tuket) begin
          doluluk <= doluluk + 1'b1;
        end else if (!cikis_it && tuket) begin
          doluluk <= doluluk - 1'b1;
        end
      end
    end
  end

  // Outstanding-address storage; contents are qualified by bekleyen.
  always_ff @(posedge clk) begin
    if (!rst && istek_ver) begin
      adres_mem[adres_son] <= istek_ps;
    end
  end

  // Instruction buffer storage; contents are qualified by doluluk.
  always_ff @(posedge clk) begin
    if (!rst && cikis_it) begin
      cikis_ps_mem[cikis_son]     <= yanit_adres;
      cikis_buyruk_mem[cikis_son] <= bellek.bellek_yanit_buyruk;
    end
  end

endmodule

// File: tb/tb_getir_birimi.sv
// Bench for getir_birimi: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_getir_birimi;
  localparam int          IMAX  = 2;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BAS   = 32'h0000_0000;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        ongoru_dallan;
  logic [31:0] ongoru_dallan_ps;
  logic        duzelt_gecerli;
  logic [31:0] duzelt_ps;
  logic        coz_hazir;
  logic [31:0] getir_ps;
  logic [31:0] getir_buyruk;
  logic        getir_gecerli;

  getir_birimi_if bif ();

  getir_birimi #(
    .BASLANGIC_PS   (BAS),
    .ISTEK_MAX      (IMAX),
    .TAMPON_DERINLIK(DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bellek          (bif),
    .ongoru_dallan   (ongoru_dallan),
    .ongoru_dallan_ps(ongoru_dallan_ps),
    .duzelt_gecerli  (duzelt_gecerli),
    .duzelt_ps       (duzelt_ps),
    .coz_hazir       (coz_hazir),
    .getir_ps        (getir_ps),
    .getir_buyruk    (getir_buyruk),
    .getir_gecerli   (getir_gecerli)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] ps; logic [31:0] buyruk; } giris_t;
  typedef struct { logic [31:0] adres; int vade; } bellek_t;

  // Reference model: outstanding addresses and buffered instructions.
  giris_t      m_cikis[$];
  logic [31:0] m_bek[$];
  logic [31:0] m_istek;
  logic [31:0] m_beklenen;

  // Memory environment and observation logs.
  bellek_t     mq[$];
  logic [31:0] tuketilen[$];
  logic [31:0] tuketilen_b[$];
  logic [31:0] istek_log[$];

  int cyc, n_test, n_hata, mq_max;
  bit durum_bilinir;
  logic son_istek_gecerli;

  logic        s_rst, s_hazir, s_coz, s_dallan, s_duzelt, s_yanit_izin;
  logic [31:0] s_dallan_ps, s_duzelt_ps;
  int          s_gecikme;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    n_test++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", ad, cyc, gercek, beklenen);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic adim();
    logic        yv, e_ig, e_v, m_issue, m_tuket, m_match, yonlendir;
    logic [31:0] e_ps, e_b, a, hedef;
    giris_t      g;
    bellek_t     yeni;
    @(negedge clk);
    rst              = s_rst;
    coz_hazir        = s_coz;
    ongoru_dallan    = s_dallan;
    ongoru_dallan_ps = s_dallan_ps;
    duzelt_gecerli   = s_duzelt;
    duzelt_ps        = s_duzelt_ps;
    bif.bellek_istek_hazir = s_hazir;
    yv = (mq.size() > 0) && s_yanit_izin && (mq[0].vade <= cyc);
    bif.bellek_yanit_gecerli = yv;
    bif.bellek_yanit_buyruk  = yv ? (mq[0].adres ^ K) : $urandom;
    #1;
    e_ig = !s_rst && (m_bek.size() < IMAX) && ((m_bek.size() + m_cikis.size()) < DEPTH) && !s_duzelt;
    e_v  = (m_cikis.size() > 0);
    e_ps = e_v ? m_cikis[0].ps : 32'h0;
    e_b  = e_v ? m_cikis[0].buyruk : 32'h0;
    son_istek_gecerli = bif.bellek_istek_gecerli;
    kontrol("istek_gecerli", 32'(bif.bellek_istek_gecerli), 32'(e_ig));
    if (e_ig) kontrol("istek_adres", bif.bellek_istek_adres, m_istek);
    if (durum_bilinir) begin
      kontrol("getir_gecerli", 32'(getir_gecerli), 32'(e_v));
      kontrol("getir_ps", getir_ps, e_ps);
      kontrol("getir_buyruk", getir_buyruk, e_b);
    end

    if (s_rst) begin
      m_cikis.delete();
      m_bek.delete();
      m_istek = BAS;
      m_beklenen = BAS;
      durum_bilinir = 1'b1;
    end else begin
      m_issue = e_ig && s_hazir;
      m_tuket = e_v && s_coz;
      m_match = 1'b0;
      a = 32'h0;
      if (yv && (m_bek.size() > 0)) begin
        a = m_bek.pop_front();
        m_match = (a == m_beklenen);
      end
      if (m_issue) m_bek.push_back(m_istek);
      hedef = {s_dallan_ps[31:2], 2'b00};
      yonlendir = m_tuket && s_dallan && (hedef != e_ps + 32'd4);
      if (s_duzelt) begin
        m_cikis.delete();
        m_istek = {s_duzelt_ps[31:2], 2'b00};
        m_beklenen = m_istek;
      end else if (yonlendir) begin
        m_cikis.delete();
        m_istek = hedef;
        m_beklenen = hedef;
      end else begin
        if (m_tuket) void'(m_cikis.pop_front());
        if (m_match) begin
          g.ps = a;
          g.buyruk = bif.bellek_yanit_buyruk;
          m_cikis.push_back(g);
          m_beklenen = m_beklenen + 32'd4;
        end
        if (m_issue) m_istek = m_istek + 32'd4;
      end
      if (!s_duzelt && getir_gecerli && s_coz) begin
        tuketilen.push_back(getir_ps);
        tuketilen_b.push_back(getir_buyruk);
      end
    end

    if (yv) void'(mq.pop_front());
    if (bif.bellek_istek_gecerli && s_hazir) begin
      yeni.adres = bif.bellek_istek_adres;
      yeni.vade  = cyc + s_gecikme;
      mq.push_back(yeni);
      istek_log.push_back(bif.bellek_istek_adres);
      if (mq.size() > mq_max) mq_max = mq.size();
    end
    cyc++;
  endtask

  task automatic varsayilan();
    s_hazir = 1'b0; s_coz = 1'b0; s_dallan = 1'b0; s_duzelt = 1'b0;
    s_yanit_izin = 1'b1; s_gecikme = 1; s_dallan_ps = 32'h0; s_duzelt_ps = 32'h0;
  endtask

  task automatic sifirla();
    varsayilan();
    s_rst = 1'b1;
    adim();
    adim();
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 0) break;
      adim();
    end
    kontrol("bellek_bosaldi", 32'(mq.size()), 32'd0);
    s_rst = 1'b0;
  endtask

  task automatic bekle_tuket(input string ad, input int hedef_sayi);
    for (int k = 0; k < 200; k++) begin
      if (tuketilen.size() >= hedef_sayi) break;
      adim();
    end
    kontrol(ad, 32'(tuketilen.size() >= hedef_sayi), 32'd1);
  endtask

  task automatic bekle_bas(input string ad, input logic [31:0] ps);
    for (int k = 0; k < 200; k++) begin
      if ((m_cikis.size() > 0) && (m_cikis[0].ps == ps)) break;
      adim();
    end
    kontrol(ad, 32'((m_cikis.size() > 0) && (m_cikis[0].ps == ps)), 32'd1);
  endtask

  initial begin
    int b, i0, i1;
    n_test = 0; n_hata = 0; cyc = 0; mq_max = 0; durum_bilinir = 1'b0;
    m_istek = BAS; m_beklenen = BAS;
    rst = 1'b1; coz_hazir = 1'b0; ongoru_dallan = 1'b0; ongoru_dallan_ps = 32'h0;
    duzelt_gecerli = 1'b0; duzelt_ps = 32'h0;
    bif.bellek_istek_hazir = 1'b0; bif.bellek_yanit_gecerli = 1'b0; bif.bellek_yanit_buyruk = 32'h0;
    s_rst = 1'b1;
    varsayilan();

    // Reset state and straight-line fetch with 1-cycle memory.
    sifirla();
    kontrol("rst_getir_gecerli", 32'(getir_gecerli), 32'd0);
    kontrol("rst_getir_ps", getir_ps, 32'h0);
    kontrol("rst_getir_buyruk", getir_buyruk, 32'h0);
    mq_max = 0;
    b = tuketilen.size(); i0 = istek_log.size();
    s_hazir = 1'b1; s_coz = 1'b1;
    bekle_tuket("s1_bekleme", b + 3);
    for (int j = 0; j < 3; j++) begin
      kontrol($sformatf("s1_ps%0d", j), tuketilen[b + j], 32'(4 * j));
      kontrol($sformatf("s1_buyruk%0d", j), tuketilen_b[b + j], 32'(4 * j) ^ K);
    end
    kontrol("s1_istek0", istek_log[i0], 32'h0);
    kontrol("s1_istek1", istek_log[i0 + 1], 32'h4);
    kontrol("s1_bekleyen_ust", 32'(mq_max <= IMAX), 32'd1);

    // Decode stall: buffer fills, requests stop, order preserved.
    sifirla();
    b = tuketilen.size();
    s_hazir = 1'b1; s_coz = 1'b1;
    bekle_tuket("s2_bekleme", b + 2);
    s_coz = 1'b0;
    for (int k = 0; k < 5; k++) adim();
    kontrol("s2_dolu_gecerli", 32'(getir_gecerli), 32'd1);
    kontrol("s2_istek_durdu", 32'(bif.bellek_istek_gecerli), 32'd0);
    kontrol("s2_bas", getir_ps, 32'h8);
    s_coz = 1'b1;
    bekle_tuket("s2_devam", b + 4);
    kontrol("s2_ps8", tuketilen[b + 2], 32'h8);
    kontrol("s2_psC", tuketilen[b + 3], 32'hC);

    // Taken prediction on head 0x10 to 0x40.
    sifirla();
    s_hazir = 1'b1; s_coz = 1'b1;
    bekle_bas("s3_bas_bekle", 32'h10);
    b = tuketilen.size();
    s_dallan = 1'b1; s_dallan_ps = 32'h40;
    adim();
    s_dallan = 1'b0;
    i1 = istek_log.size();
    bekle_tuket("s3_bekleme", b + 3);
    kontrol("s3_bas", tuketilen[b], 32'h10);
    kontrol("s3_hedef", tuketilen[b + 1], 32'h40);
    kontrol("s3_sonraki", tuketilen[b + 2], 32'h44);
    kontrol("s3_istek", istek_log[i1], 32'h40);

    // Execute correction while the buffer holds 0x20 and 0x24.
    sifirla();
    s_hazir = 1'b1; s_coz = 1'b1;
    bekle_bas("s4_bas_bekle", 32'h20);
    s_coz = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_cikis.size() == 2) break;
      adim();
    end
    kontrol("s4_dolu", 32'(m_cikis.size()), 32'd2);
    b = tuketilen.size();
    s_duzelt = 1'b1; s_duzelt_ps = 32'h200; s_coz = 1'b1;
    adim();
    s_duzelt = 1'b0;
    kontrol("s4_istek_yok", 32'(son_istek_gecerli), 32'd0);
    bekle_tuket("s4_bekleme", b + 2);
    kontrol("s4_onceki", tuketilen[b - 1], 32'h1C);
    kontrol("s4_hedef", tuketilen[b], 32'h200);
    kontrol("s4_sonraki", tuketilen[b + 1], 32'h204);

    // Correction and taken prediction together; low target bits ignored.
    sifirla();
    s_hazir = 1'b1; s_coz = 1'b1;
    b = tuketilen.size();
    for (int k = 0; k < 200; k++) begin
      if ((tuketilen.size() >= b + 2) && (m_cikis.size() > 0)) break;
      adim();
    end
    i0 = istek_log.size();
    s_duzelt = 1'b1; s_duzelt_ps = 32'h302; s_dallan = 1'b1; s_dallan_ps = 32'h81;
    adim();
    s_duzelt = 1'b0; s_dallan = 1'b0;
    i1 = istek_log.size();
    kontrol("s5_istek_yok", 32'(i1 - i0), 32'd0);
    b = tuketilen.size();
    bekle_tuket("s5_bekleme", b + 2);
    kontrol("s5_hedef", tuketilen[b], 32'h300);
    kontrol("s5_sonraki", tuketilen[b + 1], 32'h304);
    kontrol("s5_istek", istek_log[i1], 32'h300);

    // Reset with two requests outstanding; stale responses must be ignored.
    sifirla();
    s_gecikme = 3; s_hazir = 1'b1; s_coz = 1'b0;
    adim();
    adim();
    kontrol("s6_bekleyen", 32'(mq.size()), 32'd2);
    s_rst = 1'b1; s_hazir = 1'b0;
    adim();
    s_rst = 1'b0;
    for (int k = 0; k < 5; k++) adim();
    kontrol("s6_bayat_bitti", 32'(mq.size()), 32'd0);
    kontrol("s6_bos", 32'(getir_gecerli), 32'd0);
    s_gecikme = 1; s_hazir = 1'b1; s_coz = 1'b1;
    b = tuketilen.size();
    bekle_tuket("s6_bekleme", b + 1);
    kontrol("s6_ilk_ps", tuketilen[b], BAS);
    kontrol("s6_ilk_buyruk", tuketilen_b[b], BAS ^ K);

    // Address wrap from 0xFFFF_FFFC to 0.
    s_duzelt = 1'b1; s_duzelt_ps = 32'hFFFF_FFFC;
    adim();
    s_duzelt = 1'b0;
    i1 = istek_log.size();
    b = tuketilen.size();
    bekle_tuket("s7_bekleme", b + 2);
    kontrol("s7_ps_son", tuketilen[b], 32'hFFFF_FFFC);
    kontrol("s7_ps_sarma", tuketilen[b + 1], 32'h0);
    kontrol("s7_istek_son", istek_log[i1], 32'hFFFF_FFFC);
    kontrol("s7_istek_sarma", istek_log[i1 + 1], 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      s_rst        = ($urandom_range(0, 299) == 0);
      s_hazir      = ($urandom_range(0, 3) != 0);
      s_coz        = ($urandom_range(0, 3) != 0);
      s_yanit_izin = ($urandom_range(0, 3) != 0);
      s_gecikme    = $urandom_range(1, 3);
      s_dallan     = ($urandom_range(0, 7) == 0);
      if ((m_cikis.size() > 0) && ($urandom_range(0, 1) == 1))
        s_dallan_ps = m_cikis[0].ps + 32'd4 + 32'($urandom_range(0, 3));
      else
        s_dallan_ps = 32'($urandom_range(0, 1023));
      s_duzelt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        s_duzelt_ps = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        s_duzelt_ps = $urandom;
      adim();
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
    $finish;
  end
endmodule
